// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, imem handshake, one-entry hold buffer, IF/ID register
module fetch_stage #(
    parameter int                    PC_WIDTH    = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     PCwrite,
    input  logic                     IF_ID_write,
    input  logic                     redirect_valid,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    output logic                     imem_req,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic                     imem_ready,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    output logic [INSTR_WIDTH-1:0]   if_id_instr,
    output logic [PC_WIDTH-1:0]      if_id_pc4,
    output logic                     if_id_valid,
    output logic [15:0]              stall_cycles
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]  hold_instr_q, hold_instr_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [INSTR_WIDTH-1:0]  if_id_instr_q, if_id_instr_d;
    logic [PC_WIDTH-1:0]     if_id_pc4_q, if_id_pc4_d;
    logic                    if_id_valid_q, if_id_valid_d;
    logic [15:0]             stall_q, stall_d;

    logic                    in_hold;
    logic                    avail;
    logic                    advance;
    logic [INSTR_WIDTH-1:0]  instr_src;
    logic [PC_WIDTH-1:0]     pc_plus4;
    logic [PC_WIDTH-1:0]     redirect_aligned;

    // Handshake qualifiers and the datapath values shared by every branch below
    always_comb begin
        in_hold          = (state_q == S_HOLD) && hold_valid_q;
        avail            = in_hold || ((state_q == S_FETCH) && imem_ready);
        instr_src        = in_hold ? hold_instr_q : imem_rdata;
        advance          = avail && PCwrite && IF_ID_write && !redirect_valid;
        pc_plus4         = pc_q + PC_WIDTH'(4);
        redirect_aligned = redirect_pc & ~PC_WIDTH'(3);
    end

    // Next-state logic: redirect beats advance, advance beats capture/stall
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_instr_d  = hold_instr_q;
        hold_valid_d  = hold_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        stall_d       = stall_q;

        if (redirect_valid) begin
            // Flush: the wrong-path instruction (held or arriving now) is dropped
            pc_d          = redirect_aligned;
            state_d       = S_FETCH;
            hold_valid_d  = 1'b0;
            if_id_instr_d = '0;
            if_id_valid_d = 1'b0;
        end else if (advance) begin
            pc_d          = pc_plus4;
            state_d       = S_FETCH;
            hold_valid_d  = 1'b0;
            if_id_instr_d = instr_src;
            if_id_pc4_d   = pc_plus4;
            if_id_valid_d = 1'b1;
        end else begin
            if (state_q == S_START) begin
                state_d = S_FETCH;
            end else if ((state_q == S_FETCH) && imem_ready) begin
                // Park the returned word so the same address is never fetched twice
                hold_instr_d = imem_rdata;
                hold_valid_d = 1'b1;
                state_d      = S_HOLD;
            end
            if (IF_ID_write) begin
                if_id_instr_d = '0;
                if_id_valid_d = 1'b0;
            end
        end

        if ((state_q != S_START) && !advance && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // State and pipeline register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_START;
            pc_q          <= RESET_PC;
            hold_instr_q  <= '0;
            hold_valid_q  <= 1'b0;
            if_id_instr_q <= '0;
            if_id_pc4_q   <= '0;
            if_id_valid_q <= 1'b0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_valid_q  <= hold_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            stall_q       <= stall_d;
        end
    end

    // Output mapping
    always_comb begin
        imem_req     = (state_q == S_FETCH);
        imem_addr    = pc_q;
        if_id_instr  = if_id_instr_q;
        if_id_pc4    = if_id_pc4_q;
        if_id_valid  = if_id_valid_q;
        stall_cycles = stall_q;
    end

endmodule
